// File: rtl/score_pkg.sv
// Shared types, 7-segment encodings and BCD step helpers.
// Used by bcd_score_counter and bcd_to_seg7.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg7_t;

    // Active-low patterns, segment order g..a
    localparam seg7_t SEG_0     = 7'b1000000;
    localparam seg7_t SEG_1     = 7'b1111001;
    localparam seg7_t SEG_2     = 7'b0100100;
    localparam seg7_t SEG_3     = 7'b0110000;
    localparam seg7_t SEG_4     = 7'b0011001;
    localparam seg7_t SEG_5     = 7'b0010010;
    localparam seg7_t SEG_6     = 7'b0000010;
    localparam seg7_t SEG_7     = 7'b1111000;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0011000;
    localparam seg7_t SEG_BLANK = 7'b1111111;

    // Returns {digit, carry}
    function automatic logic [4:0] bcd_inc(input bcd_digit_t d,
                                           input logic cin);
        if (!cin)
            return {d, 1'b0};
        else if (d >= 4'd9)
            return {4'd0, 1'b1};
        else
            return {d + 4'd1, 1'b0};
    endfunction

    // Returns {digit, borrow}
    function automatic logic [4:0] bcd_dec(input bcd_digit_t d,
                                           input logic bin);
        if (!bin)
            return {d, 1'b0};
        else if (d == 4'd0)
            return {4'd9, 1'b1};
        else
            return {d - 4'd1, 1'b0};
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to a 7-segment pattern (g..a).
// Illegal nibbles and blank requests turn every segment off.
module bcd_to_seg7
    import score_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       blank,
    input  logic       active_low,
    output seg7_t      seg
);

    seg7_t pat;

    always_comb begin
        pat = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    pat = SEG_0;
                4'd1:    pat = SEG_1;
                4'd2:    pat = SEG_2;
                4'd3:    pat = SEG_3;
                4'd4:    pat = SEG_4;
                4'd5:    pat = SEG_5;
                4'd6:    pat = SEG_6;
                4'd7:    pat = SEG_7;
                4'd8:    pat = SEG_8;
                4'd9:    pat = SEG_9;
                default: pat = SEG_BLANK;
            endcase
        end
        seg = active_low ? pat : ~pat;
    end

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit up/down BCD score counter with 7-segment outputs.
// SCORE_LEADING_BLANK_EN blanks leading zero digits above digit 0.
module bcd_score_counter
    import score_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int SATURATE       = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                point,
    input  logic                penalty,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic [7*DIGITS-1:0] score_seg,
    output logic                overflow,
    output logic                at_zero
);

    bcd_digit_t [DIGITS-1:0] digits;
    bcd_digit_t [DIGITS-1:0] clean;
    bcd_digit_t [DIGITS-1:0] inc_val;
    bcd_digit_t [DIGITS-1:0] dec_val;
    bcd_digit_t [DIGITS-1:0] next;
    logic                    carry;
    logic                    borrow;
    logic                    ovf_next;
    logic [4:0]              inc_r;
    logic [4:0]              dec_r;
    logic [DIGITS-1:0]       blank;

    // Both ripple chains are evaluated every cycle; illegal nibbles count as 0
    always_comb begin
        clean   = '0;
        inc_val = '0;
        dec_val = '0;
        inc_r   = '0;
        dec_r   = '0;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            clean[i]   = (digits[i] > 4'd9) ? 4'd0 : digits[i];
            inc_r      = bcd_inc(clean[i], carry);
            inc_val[i] = inc_r[4:1];
            carry      = inc_r[0];
            dec_r      = bcd_dec(clean[i], borrow);
            dec_val[i] = dec_r[4:1];
            borrow     = dec_r[0];
        end
    end

    always_comb begin
        next     = digits;
        ovf_next = 1'b0;
        if (clear) begin
            next = '0;
        end else if (point && !penalty) begin
            ovf_next = carry;
            // A carry out means every digit was 9, so clean is all-nines
            next = (carry && SATURATE != 0) ? clean : inc_val;
        end else if (penalty && !point) begin
            next = borrow ? '0 : dec_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits   <= '0;
            overflow <= 1'b0;
        end else begin
            digits   <= next;
            overflow <= ovf_next;
        end
    end

    assign score_bcd = digits;
    assign at_zero   = (digits == '0);

`ifdef SCORE_LEADING_BLANK_EN
    logic lead;

    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead     = lead && (digits[i] == 4'd0);
            blank[i] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_to_seg7 u_seg (
            .digit      (digits[g]),
            .blank      (blank[g]),
            .active_low (SEG_ACTIVE_LOW != 0),
            .seg        (score_seg[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed bench for bcd_score_counter: wrap, saturate, borrow,
// clear priority, async reset and segment/blanking patterns.
module tb_bcd_score_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic point = 1'b0;
    logic penalty = 1'b0;

    logic [7:0]  b2, bs;
    logic [11:0] b3;
    logic [13:0] s2, ss;
    logic [20:0] s3;
    logic        o2, os, o3;
    logic        z2, zs, z3;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] tbl [10];
    logic [6:0] lead_exp;

    always #5 clk = ~clk;

    bcd_score_counter #(.DIGITS(2), .SATURATE(0), .SEG_ACTIVE_LOW(1)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .point(point),
        .penalty(penalty), .score_bcd(b2), .score_seg(s2),
        .overflow(o2), .at_zero(z2)
    );

    bcd_score_counter #(.DIGITS(2), .SATURATE(1), .SEG_ACTIVE_LOW(1)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .point(point),
        .penalty(penalty), .score_bcd(bs), .score_seg(ss),
        .overflow(os), .at_zero(zs)
    );

    bcd_score_counter #(.DIGITS(3), .SATURATE(0), .SEG_ACTIVE_LOW(1)) dut3 (
        .clk(clk), .reset(reset), .clear(clear), .point(point),
        .penalty(penalty), .score_bcd(b3), .score_seg(s3),
        .overflow(o3), .at_zero(z3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic pts(input int n);
        point = 1'b1;
        repeat (n) tick();
        point = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (b2 !== 8'h00 || z2 !== 1'b1 || o2 !== 1'b0) begin
            miscompares++;
            $display("FAIL por_state got bcd=%h z=%b o=%b want 00 1 0", b2, z2, o2);
        end
        reset = 1'b0;
        tick();
        pts(37);
        vectors++;
        if (b2 !== 8'h37) begin
            miscompares++;
            $display("FAIL count37 got %h want 37", b2);
        end
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (b2 !== 8'h00 || z2 !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset got bcd=%h z=%b want 00 1", b2, z2);
        end
        vectors++;
        if (s2 !== 14'b1000000_1000000) begin
            miscompares++;
            $display("FAIL reset_seg got %b want 10000001000000", s2);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_carry();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (s2[6:0] !== tbl[i] || b2[3:0] !== 4'(i)) begin
                miscompares++;
                $display("FAIL seg_digit%0d got %b/%h want %b/%0d", i, s2[6:0], b2[3:0], tbl[i], i);
            end
            if (i < 9) pts(1);
        end
        pts(1);
        vectors++;
        if (b2 !== 8'h10 || o2 !== 1'b0) begin
            miscompares++;
            $display("FAIL carry_09 got %h o=%b want 10 0", b2, o2);
        end
        vectors++;
        if (s2[13:7] !== 7'b1111001 || s2[6:0] !== 7'b1000000) begin
            miscompares++;
            $display("FAIL carry_seg got %b want 11110011000000", s2);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pts(99);
        vectors++;
        if (b2 !== 8'h99 || o2 !== 1'b0) begin
            miscompares++;
            $display("FAIL at99 got %h o=%b want 99 0", b2, o2);
        end
        point = 1'b1;
        tick();
        vectors++;
        if (b2 !== 8'h00 || o2 !== 1'b1 || z2 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap got %h o=%b z=%b want 00 1 1", b2, o2, z2);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if (b2 !== 8'(k) || o2 !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_hold%0d got %h o=%b want 0%0d 0", k, b2, o2, k);
            end
        end
        point = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        pts(99);
        point = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (bs !== 8'h99 || os !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_hold%0d got %h o=%b want 99 1", k, bs, os);
            end
        end
        point = 1'b0;
        tick();
        vectors++;
        if (bs !== 8'h99 || os !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_release got %h o=%b want 99 0", bs, os);
        end
    endtask

    task automatic test_penalty();
        do_reset();
        pts(10);
        penalty = 1'b1;
        tick();
        penalty = 1'b0;
        vectors++;
        if (b2 !== 8'h09) begin
            miscompares++;
            $display("FAIL borrow10 got %h want 09", b2);
        end
        penalty = 1'b1;
        repeat (3) tick();
        penalty = 1'b0;
        vectors++;
        if (b2 !== 8'h06) begin
            miscompares++;
            $display("FAIL pen3 got %h want 06", b2);
        end
        point = 1'b1;
        penalty = 1'b1;
        tick();
        point = 1'b0;
        penalty = 1'b0;
        vectors++;
        if (b2 !== 8'h06 || o2 !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel got %h o=%b want 06 0", b2, o2);
        end
        do_reset();
        penalty = 1'b1;
        tick();
        penalty = 1'b0;
        vectors++;
        if (b2 !== 8'h00 || o2 !== 1'b0 || z2 !== 1'b1) begin
            miscompares++;
            $display("FAIL floor got %h o=%b z=%b want 00 0 1", b2, o2, z2);
        end
    endtask

    task automatic test_clear();
        do_reset();
        pts(45);
        clear = 1'b1;
        point = 1'b1;
        tick();
        clear = 1'b0;
        point = 1'b0;
        vectors++;
        if (b2 !== 8'h00 || o2 !== 1'b0 || z2 !== 1'b1) begin
            miscompares++;
            $display("FAIL clear got %h o=%b z=%b want 00 0 1", b2, o2, z2);
        end
    endtask

    task automatic test_blank();
        do_reset();
        pts(7);
`ifdef SCORE_LEADING_BLANK_EN
        lead_exp = 7'b1111111;
`else
        lead_exp = 7'b1000000;
`endif
        vectors++;
        if (b3 !== 12'h007 || z3 !== 1'b0 || o3 !== 1'b0) begin
            miscompares++;
            $display("FAIL d3_007 got %h z=%b o=%b want 007 0 0", b3, z3, o3);
        end
        vectors++;
        if (s3[20:14] !== lead_exp || s3[13:7] !== lead_exp || s3[6:0] !== 7'b1111000) begin
            miscompares++;
            $display("FAIL blank_seg got %b want %b%b1111000", s3, lead_exp, lead_exp);
        end
        vectors++;
        if (s2[13:7] !== lead_exp) begin
            miscompares++;
            $display("FAIL blank_d2 got %b want %b", s2[13:7], lead_exp);
        end
    endtask

    initial begin
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001;
        tbl[2] = 7'b0100100; tbl[3] = 7'b0110000;
        tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000;
        tbl[8] = 7'b0000000; tbl[9] = 7'b0011000;
        test_reset();
        test_carry();
        test_wrap();
        test_saturate();
        test_penalty();
        test_clear();
        test_blank();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_score_counter.md
Name: bcd_score_counter

Overview:
- Parametrised multi-digit BCD score counter with built-in 7-segment encoding, for HEX display banks.
- Successor to the single-digit score FSM.
- Adds configurable digit count, up/down scoring, and a wrap or saturate mode.
- Sits between game-event logic (frog reaches home, frog dies) and the HEX displays. Its overflow pulse can cascade into a further counter.

Parameters:
- DIGITS, 3: number of BCD digits, 1..6; digit 0 is the least significant.
- SATURATE, 0: 0 = wrap from all-nines to zero; 1 = hold at all-nines.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs active-low (HEX convention); 0 = active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous and active-high
- clear  in  1  synchronous clear to zero
- point  in  1  increment score by 1 this cycle
- penalty  in  1  decrement score by 1 this cycle
- score_bcd  out  4*DIGITS  registered BCD score; digit i is bits [4i+3:4i]
- score_seg  out  7*DIGITS  7-segment pattern per digit; digit i is bits [7i+6:7i], segment order g..a (MSB..LSB)
- overflow  out  1  one-cycle pulse on wrap (or attempted wrap when saturating)
- at_zero  out  1  high when every digit is 0

Behaviour:
- Reset (async, any time):
  - all digits 0, overflow 0, at_zero 1
  - score_seg shows "0" on every digit (1000000 per digit when active-low)
  - takes effect immediately, including mid-carry.
- Priority each rising clk edge: reset > clear > (point XOR penalty) > hold.
- clear: all digits 0 next cycle, overflow 0. Any point/penalty in the same cycle is ignored.
- point && penalty together: they cancel, score holds, no pulse.
- Increment (point only):
  - digit 0 goes +1; a digit at 9 becomes 0 and carries into the next digit.
  - Carry ripples combinationally through all DIGITS within one cycle.
  - The new score is visible on score_bcd the cycle after the edge (latency 1).
- Increment from all-nines:
  - SATURATE=0: score becomes 0 and overflow=1 for exactly that following cycle.
  - SATURATE=1: score stays all-nines and overflow=1 for one cycle. This pulse marks lost points.
- Decrement (penalty only):
  - digit 0 goes -1; a digit at 0 becomes 9 and borrows from the next digit.
  - At zero the score floors: stays 0, no borrow, no overflow, no wrap to all-nines.
- overflow is registered: high for one cycle only, even if point is held continuously. Each qualifying edge produces its own pulse, so consecutive wraps give back-to-back pulses.
- Held point: +1 per clk edge. Debouncing or edge detection is upstream's job.
- Digits never leave 0..9. An illegal stored nibble (SEU) is treated as 0 on the next update; the display shows blank (all segments off) for that digit.
- score_seg and at_zero are combinational from the registered digits. No extra latency relative to score_bcd.
- Segment patterns (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - SEG_ACTIVE_LOW=0 inverts every pattern.

Optional Feature:
- Macro: SCORE_LEADING_BLANK_EN.
- Defined: a digit above digit 0 whose value is 0, with all more-significant digits also 0, drives all segments off (blank). Digit 0 is never blanked, so a zero score shows a single "0". Example: 007 displays as "  7".
- Not defined: every digit always shows its numeral, e.g. "007".
- score_bcd, overflow and at_zero are identical either way.

Decomposition:
- Package score_pkg:
  - typedef bcd_digit_t (logic [3:0])
  - typedef seg7_t (logic [6:0])
  - constants SEG_0..SEG_9 and SEG_BLANK (active-low encodings)
  - function bcd_inc / bcd_dec, each returning {digit, carry/borrow}
- Sub-module bcd_to_seg7:
  - purely combinational, one instance per digit via generate
  - inputs: digit, blank, active_low
  - output: seg7_t
- The counter core stays in bcd_score_counter.

Test Plan (DIGITS=2 unless stated):
1. Reset while score=37, asserted asynchronously mid-cycle -> score_bcd=8'h00 before the next clk edge, at_zero=1, score_seg={1000000,1000000}.
2. Pulse point once from 09 -> score_bcd=8'h10 one cycle later; digit1 seg=1111001, digit0 seg=1000000; overflow stays 0.
3. SATURATE=0, score 99, point -> 00 with overflow=1 for exactly one cycle. Then hold point for 3 cycles -> 01, 02, 03 with no overflow.
4. SATURATE=1, score 99, point held for 2 cycles -> stays 99, overflow high for 2 consecutive cycles, then 0 once point drops.
5. From 10: penalty -> 09; three more penalties -> 06. From 00: penalty -> 00, no overflow. point && penalty at 06 -> 06.
6. Score 45, assert clear together with point -> 00 next cycle. With SCORE_LEADING_BLANK_EN and DIGITS=3 at score 007 -> digit2 and digit1 segments = 1111111, digit0 = 1111000.
